sgf_round_norm: RTL and testbench

SGF_ROUND_NORM -- requirements
Module: sgf_round_norm

---
 rtl/sgf_round_norm.sv | 124 ++++++++++++
 tb/tb_sgf_round_norm.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sgf_round_norm.sv
// sgf_round_norm: two-stage normalize + round for a significand product.
// S1 picks the P-bit mantissa window from the 2P-bit product and captures
// guard/sticky; S2 applies the rounding mode and folds any carry-out into
// the exponent adjustment. Valid/ready handshake on both sides; each stage
// loads only when its downstream can take its current contents.
module sgf_round_norm #(
  parameter int SW = 54,
  parameter int P  = 53
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2*SW-1:0] product_i,
  input  logic            sign_i,
  input  logic [1:0]      rmode_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [P-1:0]    sgf_o,
  output logic [1:0]      exp_adj_o,
  output logic            inexact_o,
  output logic            zero_o
);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RZ  = 2'b01;
  localparam logic [1:0] RM_RU  = 2'b10;

  typedef struct packed {
    logic [P-1:0] mant;
    logic         guard;
    logic         sticky;
    logic         n;
    logic         zero;
    logic         sign;
    logic [1:0]   rmode;
  } s1_t;

  // vld_pipe[0] is the incoming valid; [1] and [2] are the stage valids.
  logic [2:0] vld_pipe;
  logic       adv1, adv2;
  s1_t        s1_n, s1_q;

  assign vld_pipe[0] = valid_i;
  assign adv2        = !vld_pipe[2] || ready_i;
  assign adv1        = !vld_pipe[1] || adv2;
  assign ready_o     = adv1;
  assign valid_o     = vld_pipe[2];

  // Normalize: the product of two normal significands has its MSB at 2P-1
  // or 2P-2; denormal operands just take the lower window with no further
  // shift. Zero detection spans the full input so the high bits count too.
  always_comb begin
    s1_n       = '0;
    s1_n.n     = product_i[2*P-1];
    s1_n.zero  = (product_i == '0);
    s1_n.sign  = sign_i;
    s1_n.rmode = rmode_i;
    if (product_i[2*P-1]) begin
      s1_n.mant   = product_i[2*P-1:P];
      s1_n.guard  = product_i[P-1];
      s1_n.sticky = |product_i[P-2:0];
    end else begin
      s1_n.mant   = product_i[2*P-2:P-1];
      s1_n.guard  = product_i[P-2];
      s1_n.sticky = |product_i[P-3:0];
    end
  end

  // S1 register: capture normalized fields when the stage advances.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe[1] <= 1'b0;
      s1_q        <= '0;
    end else if (adv1) begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) s1_q <= s1_n;
    end
  end

  logic         inc, carry, lost;
  logic [P:0]   sum;
  logic [P-1:0] sgf_n;
  logic [1:0]   adj_n;

  // Round: increment decision per mode, then fold carry-out into exponent.
  always_comb begin
    lost = s1_q.guard | s1_q.sticky;
    case (s1_q.rmode)
      RM_RNE:  inc = s1_q.guard & (s1_q.sticky | s1_q.mant[0]);
      RM_RZ:   inc = 1'b0;
      RM_RU:   inc = !s1_q.sign & lost;
      default: inc = s1_q.sign & lost;
    endcase
    sum   = {1'b0, s1_q.mant} + {{P{1'b0}}, inc};
    carry = sum[P];
    sgf_n = carry ? {1'b1, {(P-1){1'b0}}} : sum[P-1:0];
    adj_n = {1'b0, s1_q.n} + {1'b0, carry};
    if (s1_q.zero) begin
      sgf_n = '0;
      adj_n = 2'd0;
    end
  end

  // S2 register: rounded result, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe[2] <= 1'b0;
      sgf_o       <= '0;
      exp_adj_o   <= 2'd0;
      inexact_o   <= 1'b0;
      zero_o      <= 1'b0;
    end else if (adv2) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        sgf_o     <= sgf_n;
        exp_adj_o <= adj_n;
        inexact_o <= lost & !s1_q.zero;
        zero_o    <= s1_q.zero;
      end
    end
  end

endmodule

// File: tb/tb_sgf_round_norm.sv
// Bench for sgf_round_norm: arithmetic reference model + scoreboard,
// random and directed stimulus, backpressure and mid-flight reset.
module tb_sgf_round_norm;
  localparam int SW = 54;
  localparam int P  = 53;
  localparam int W  = 2*SW;

  typedef struct packed {
    logic [P-1:0] sgf;
    logic [1:0]   adj;
    logic         inx;
    logic         zero;
  } res_t;

  logic         clk, rst, valid_i, ready_o, sign_i, valid_o, ready_i;
  logic [W-1:0] product_i;
  logic [1:0]   rmode_i;
  logic [P-1:0] sgf_o;
  logic [1:0]   exp_adj_o;
  logic         inexact_o, zero_o;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];
  res_t snap;
  bit   snap_v = 0;
  bit   rnd_done = 0;

  sgf_round_norm #(.SW(SW), .P(P)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .product_i(product_i), .sign_i(sign_i), .rmode_i(rmode_i),
    .valid_o(valid_o), .ready_i(ready_i), .sgf_o(sgf_o),
    .exp_adj_o(exp_adj_o), .inexact_o(inexact_o), .zero_o(zero_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Reference: value = mant * 2^sh + rem, rounded by comparing rem to half an ulp.
  function automatic res_t model(input logic [W-1:0] p, input logic s, input logic [1:0] r);
    res_t e;
    int sh;
    logic [W-1:0] one, mant, rem, half;
    logic up;
    one = 1;
    e = '0;
    if (p == 0) begin
      e.zero = 1'b1;
      return e;
    end
    sh   = p[2*P-1] ? P : P-1;
    mant = p >> sh;
    rem  = p & ((one << sh) - one);
    half = one << (sh-1);
    case (r)
      2'd0:    up = (rem > half) || (rem == half && mant[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !s && rem != 0;
      default: up = s && rem != 0;
    endcase
    mant  = mant + W'(up);
    e.adj = (sh == P) ? 2'd1 : 2'd0;
    if (mant == (one << P)) begin
      mant  = mant >> 1;
      e.adj = e.adj + 2'd1;
    end
    e.sgf = mant[P-1:0];
    e.inx = rem != 0;
    return e;
  endfunction

  // Scoreboard: handshakes are decided before the next posedge, so sample at negedge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      snap_v = 0;
    end else begin
      if (snap_v) begin
        chk("hold", {sgf_o, exp_adj_o, inexact_o, zero_o}, snap);
        snap_v = 0;
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          chk("result", {sgf_o, exp_adj_o, inexact_o, zero_o}, exp_q.pop_front());
        end
      end else if (valid_o) begin
        snap   = {sgf_o, exp_adj_o, inexact_o, zero_o};
        snap_v = 1;
      end
      if (valid_i && ready_o) exp_q.push_back(model(product_i, sign_i, rmode_i));
    end
  end

  // Call just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [W-1:0] p, input logic s, input logic [1:0] r);
    valid_i = 1; product_i = p; sign_i = s; rmode_i = r;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ready_o) begin
        @(posedge clk); #1;
        valid_i = 0;
        return;
      end
    end
    chk("send_timeout", 1, 0);
    valid_i = 0;
  endtask

  function automatic logic [P-1:0] rsig();
    logic [63:0] r;
    logic [P-1:0] v;
    r = {$urandom(), $urandom()};
    v = r[P-1:0];
    v[P-1] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] rprod();
    logic [W-1:0] a, b, one, low;
    int sh, k;
    one = 1;
    k = $urandom_range(0, 11);
    sh = $urandom_range(0, 1) ? P : P-1;
    low = {$urandom(), $urandom()};
    low = low & ((one << (sh-1)) - one);
    a = W'(rsig());
    b = W'(rsig());
    case (k)
      0,1,2,3,4: return a * b;
      5:         return (a >> $urandom_range(1, P-1)) * b;
      6:         return 0;
      7:         return (a << sh) | (one << (sh-1));
      8:         return (a << sh) | (one << (sh-1)) | low;
      9:         return (((one << P) - one) << sh) | (one << (sh-1)) | low;
      10:        return (((one << P) - one) << sh) | low;
      default:   return (a << sh) | low;
    endcase
  endfunction

  initial begin
    logic [W-1:0] one, x104, sq, ones;
    one  = 1;
    x104 = one << 104;
    sq   = ((one << 53) - one) * ((one << 53) - one);
    ones = ((one << 54) - one) << 51;
    rst = 0; valid_i = 0; ready_i = 1; product_i = '0; sign_i = 0; rmode_i = 0;

    // Model pins from hand-worked values.
    chk("pin_exact",   model(x104, 0, 0), {53'h10000000000000, 2'd0, 1'b0, 1'b0});
    chk("pin_sq_rne",  model(sq, 0, 0),   {53'h1FFFFFFFFFFFFE, 2'd1, 1'b1, 1'b0});
    chk("pin_sq_ru",   model(sq, 0, 2),   {53'h1FFFFFFFFFFFFF, 2'd1, 1'b1, 1'b0});
    chk("pin_tie_even", model(x104 | (one << 51), 0, 0), {53'h10000000000000, 2'd0, 1'b1, 1'b0});
    chk("pin_tie_odd", model(x104 | (one << 52) | (one << 51), 0, 0), {53'h10000000000002, 2'd0, 1'b1, 1'b0});
    chk("pin_carry",   model(ones, 0, 0), {53'h10000000000000, 2'd1, 1'b1, 1'b0});
    chk("pin_zero",    model('0, 1, 3),   {53'h0, 2'd0, 1'b0, 1'b1});
    chk("pin_sq_rd_neg", model(sq, 1, 3), {53'h1FFFFFFFFFFFFF, 2'd1, 1'b1, 1'b0});

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {valid_o, sgf_o, exp_adj_o, inexact_o, zero_o}, '0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("post_reset_hs", {ready_o, valid_o}, 2'b10);
    @(posedge clk); #1;

    // Latency: result visible two edges after acceptance.
    send(x104, 0, 0);
    @(negedge clk);
    chk("latency_early", valid_o, 0);
    @(negedge clk);
    chk("latency_valid", valid_o, 1);
    chk("latency_data", {sgf_o, exp_adj_o, inexact_o, zero_o}, {53'h10000000000000, 2'd0, 1'b0, 1'b0});
    @(posedge clk); #1;

    // Directed corners through the scoreboard, back to back.
    send(sq, 0, 0);
    send(sq, 0, 2);
    send(x104 | (one << 51), 0, 0);
    send(x104 | (one << 52) | (one << 51), 0, 0);
    send(ones, 0, 0);
    send('0, 1, 2);
    send(one << 40, 0, 0);  // denormal operand: no extra shift

    // Backpressure: ready_i low for 3 edges while streaming 4 items.
    ready_i = 0;
    fork
      begin
        send(sq, 1, 3); send(x104 | 5, 0, 2); send(sq, 0, 1); send(ones, 1, 0);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_ready_drop", ready_o, 0);
        @(posedge clk); #1 ready_i = 1;
      end
    join
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    chk("bp_drained", exp_q.size(), 0);
    @(posedge clk); #1;

    // Random traffic with random downstream stalls.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(rprod(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_i = 1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    chk("rnd_drained", exp_q.size(), 0);
    @(posedge clk); #1;

    // Reset with both stages full: nothing stale may come out afterwards.
    ready_i = 0;
    send(sq, 0, 0);
    send(x104, 0, 0);
    @(negedge clk);
    chk("full_before_rst", {valid_o, ready_o}, 2'b10);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 rst = 1; ready_i = 1;
    @(negedge clk);
    chk("rst_flush", {valid_o, ready_o}, 2'b01);
    repeat (10) @(negedge clk);
    chk("no_stale", valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
